md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
- REQ-001 Parameter WIDTH, default 32: operand and HI/LO width in bits (WIDTH >= 2).
- REQ-002 Parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU (>= 1).
- REQ-003 Parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU (>= 1).
- REQ-004 Clocking: one clock; reset is asynchronous and active-low.
- REQ-005 clk  input  1  rising-edge clock.
- REQ-006 reset_n  input  1  asynchronous active-low reset.
- REQ-007 start  input  1  request strobe, sampled each rising edge.
- REQ-008 op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved.
- REQ-009 a  input  WIDTH  operand rs (dividend / MTHI-MTLO source).
- REQ-010 b  input  WIDTH  operand rt (divisor).
- REQ-011 cancel  input  1  abort of any in-flight operation (pipeline flush).
- REQ-012 busy  output  1  operation in flight; high stalls dependent MD instructions.
- REQ-013 hi  output  WIDTH  HI register.
- REQ-014 lo  output  WIDTH  LO register.

Function
- REQ-015 States: IDLE and RUN; state, countdown counter, pending HI/LO and the HI/LO registers are all registered.
- REQ-016 In IDLE, start=1 with op 0-3 and cancel=0 latches the result into pending registers, loads the counter with MULT_CYCLES or DIV_CYCLES, and enters RUN.
- REQ-017 busy = (state == RUN); a start accepted at edge t gives busy=1 for exactly N cycles after t (N per REQ-002/003), then busy=0.
- REQ-018 HI/LO update on the edge that leaves RUN; new values are visible in the same cycle busy first reads 0.
- REQ-019 In IDLE, start=1 with op 4 (MTHI) or 5 (MTLO) and cancel=0 writes a to hi or lo at that edge; the state stays IDLE and busy stays 0.
- REQ-020 MULT: signed 2*WIDTH product, hi = upper WIDTH bits, lo = lower WIDTH bits. MULTU: unsigned product.
- REQ-021 DIV: signed division with quotient truncated toward zero; lo = quotient, hi = remainder carrying the sign of the dividend. DIVU: unsigned.
- REQ-022 DIV with a = most-negative value and b = -1: lo = most-negative value, hi = 0.
- REQ-023 DIV/DIVU with b = 0: the operation completes with normal busy timing, and hi and lo are left unchanged.
- REQ-024 Any start while in RUN is ignored: no queueing, and the in-flight operation is unaffected.
- REQ-025 Reserved op codes with start=1 are ignored in both states.
- REQ-026 cancel=1 in RUN: return to IDLE at the next edge with hi/lo unchanged; busy is 0 in the following cycle.
- REQ-027 cancel=1 together with start=1 in IDLE: the start is dropped, including MTHI/MTLO.
- REQ-028 cancel=1 on the final RUN cycle (counter = 1): the cancel wins and hi/lo are not written.
- REQ-029 Operands are sampled only on the accepting edge; changes to a/b during RUN have no effect.

Reset
- REQ-030 reset_n=0 forces IDLE immediately, without waiting for clk; busy=0, hi=0, lo=0, counter=0, pending=0.
- REQ-031 Reset asserted during RUN discards the operation; after release the block accepts a new start on the first rising edge.
- REQ-032 Outputs hold their reset values for as long as reset_n=0, regardless of start and cancel.

Verification
- REQ-033 MULT a=-3 (0xFFFFFFFD), b=7, defaults -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- REQ-034 DIV a=-7, b=2 -> busy high 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 7/2 -> lo=3, hi=1.
- REQ-035 MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 -> hi/lo take those values on the respective edges, and busy never rises.
- REQ-036 MULTU 0xFFFFFFFF x 2 -> hi=1, lo=0xFFFFFFFE. A second start in the 3rd busy cycle is ignored, and busy ends at cycle 5.
- REQ-037 DIV with b=0 after hi=5, lo=6 -> busy 10 cycles, then hi=5, lo=6. Cancel in busy cycle 4 of a DIV -> busy 0 next cycle, and hi/lo unchanged.
- REQ-038 Reset pulse mid-MULT -> busy, hi and lo are 0 asynchronously. Re-run with MULT_CYCLES=1, DIV_CYCLES=33, WIDTH=16 -> results and latencies match REQ-017 to REQ-022.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers. It takes one request at a time, holds it
// busy for a fixed number of cycles, and supports cancel (pipeline flush).
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  logic            pend_wr;

  // Products are formed at full 2*WIDTH width so the upper half is exact.
  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign a_zx   = {{WIDTH{1'b0}}, a};
  assign b_zx   = {{WIDTH{1'b0}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Division runs on magnitudes and restores signs afterwards. The magnitude of the
  // most-negative value is still representable unsigned, so MIN / -1 needs no special case.
  logic             sgn, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag, div_b, q_mag, r_mag, quot, rem;
  assign sgn    = (op == OP_DIV);
  assign a_neg  = sgn & a[WIDTH-1];
  assign b_neg  = sgn & b[WIDTH-1];
  assign b_zero = (b == '0);
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign div_b  = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign q_mag  = a_mag / div_b;
  assign r_mag  = a_mag % div_b;
  assign quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem    = a_neg ? -r_mag : r_mag;

  assign busy = (state == RUN);

  // NOTE: all state is assigned with non-blocking (<=) so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                {pend_hi, pend_lo} <= (op == OP_MULT) ? prod_s : prod_u;
                pend_wr <= 1'b1;
                cnt     <= CW'(MULT_CYCLES);
                state   <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                pend_hi <= rem;
                pend_lo <= quot;
                pend_wr <= !b_zero;
                cnt     <= CW'(DIV_CYCLES);
                state   <= RUN;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          // Cancel beats completion, even on the final cycle.
          if (cancel) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CW'(1)) begin
            state <= IDLE;
            cnt   <= '0;
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, hand-written corner
// sequences and random operations checked against an arithmetic model, on two configurations.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, cancel, sel;
  logic [2:0]  op_r;
  logic [31:0] a_r, b_r;

  logic        busy32, busy16;
  logic [31:0] hi32, lo32;
  logic [15:0] hi16, lo16;

  logic        busy_s;
  logic [31:0] hi_s, lo_s;

  assign busy_s = sel ? busy16 : busy32;
  assign hi_s   = sel ? {16'h0, hi16} : hi32;
  assign lo_s   = sel ? {16'h0, lo16} : lo32;

  md_unit u_dut (
    .clk(clk), .reset_n(reset_n), .start(start & ~sel), .op(op_r), .a(a_r), .b(b_r),
    .cancel(cancel & ~sel), .busy(busy32), .hi(hi32), .lo(lo32)
  );

  md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(33)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .start(start & sel), .op(op_r), .a(a_r[15:0]),
    .b(b_r[15:0]), .cancel(cancel & sel), .busy(busy16), .hi(hi16), .lo(lo16)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int w  = 32;
  int nm = 5;
  int nd = 10;
  logic [31:0] m_hi, m_lo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands interpreted at width w.
  function automatic void model(input logic [2:0] op_i, input logic [31:0] a_i,
                                input logic [31:0] b_i, output bit wr,
                                output logic [31:0] h, output logic [31:0] l);
    logic [31:0] m;
    longint      ua, ub, sa, sb, q, r;
    logic [63:0] p;
    m  = 32'hFFFF_FFFF >> (32 - w);
    ua = longint'(a_i & m);
    ub = longint'(b_i & m);
    sa = a_i[w-1] ? ua - (longint'(1) << w) : ua;
    sb = b_i[w-1] ? ub - (longint'(1) << w) : ub;
    wr = 1'b1;
    h  = '0;
    l  = '0;
    p  = '0;
    q  = 0;
    r  = 0;
    case (op_i)
      3'd0: p = 64'(sa * sb);
      3'd1: p = {32'h0, a_i & m} * {32'h0, b_i & m};
      3'd2: if (ub == 0) wr = 1'b0; else begin q = sa / sb; r = sa % sb; end
      default: if (ub == 0) wr = 1'b0; else begin q = ua / ub; r = ua % ub; end
    endcase
    if (op_i < 3'd2) begin
      l = p[31:0] & m;
      h = 32'(p >> w) & m;
    end else begin
      l = 32'(q) & m;
      h = 32'(r) & m;
    end
  endfunction

  // Entered and left at a negedge. inj_at>0 drives cancel (or a stray start) during that busy cycle.
  task automatic run_vec(input string name, input logic [2:0] op_i, input logic [31:0] a_i,
                         input logic [31:0] b_i, input logic [31:0] eh, input logic [31:0] el,
                         input int en, input int inj_at, input bit inj_cancel);
    int n;
    op_r = op_i; a_r = a_i; b_r = b_i; start = 1'b1; cancel = 1'b0;
    @(negedge clk);
    start = 1'b0;
    a_r = $urandom;
    b_r = $urandom;
    n = 0;
    while (busy_s === 1'b1 && n < 100) begin
      n++;
      if (n == inj_at) begin
        if (inj_cancel) cancel = 1'b1;
        else begin start = 1'b1; op_r = 3'($urandom_range(0, 5)); end
      end else begin
        start = 1'b0; cancel = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; cancel = 1'b0;
    check({name, " latency"}, 32'(n), 32'(en));
    check({name, " hi"}, hi_s, eh);
    check({name, " lo"}, lo_s, el);
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic rand_op(input int idx);
    logic [2:0]  o;
    logic [31:0] ra, rb, eh, el, m;
    bit          wr;
    int          n, inj, k;
    m  = 32'hFFFF_FFFF >> (32 - w);
    o  = 3'($urandom_range(0, 7));
    ra = $urandom;
    rb = $urandom;
    case ($urandom_range(0, 7))
      0: rb = 32'h0;
      1: begin ra = 32'h1 << (w - 1); rb = 32'hFFFF_FFFF; end
      2: rb = 32'($urandom_range(1, 9));
      default: ;
    endcase
    eh = m_hi; el = m_lo; n = 0; inj = 0; k = 0;
    case (o)
      3'd4: eh = ra & m;
      3'd5: el = ra & m;
      3'd6, 3'd7: ;
      default: begin
        n = (o < 3'd2) ? nm : nd;
        model(o, ra, rb, wr, eh, el);
        if (!wr) begin eh = m_hi; el = m_lo; end
        inj = $urandom_range(0, 3);
        k = $urandom_range(1, n);
        if (inj == 0) begin eh = m_hi; el = m_lo; n = k; end
      end
    endcase
    run_vec($sformatf("rnd%0d op%0d", idx, o), o, ra, rb, eh, el, n,
            (inj < 2) ? k : 0, inj == 0);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    int          en, inj_at;
    bit          inj_cancel;
  } vec_t;

  vec_t vt[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt.push_back('{"mult -3x7",    3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5, 0, 0});
    vt.push_back('{"div -7/2",     3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0, 0});
    vt.push_back('{"divu 7/2",     3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10, 0, 0});
    vt.push_back('{"mthi",         3'd4, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'd3, 0, 0, 0});
    vt.push_back('{"mtlo",         3'd5, 32'h9ABC_DEF0, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0});
    vt.push_back('{"multu+start",  3'd1, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 5, 3, 0});
    vt.push_back('{"div min/-1",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 0, 0});
    vt.push_back('{"mult min*min", 3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 5, 0, 0});
    vt.push_back('{"mthi 5",       3'd4, 32'd5, 32'd9, 32'd5, 32'd0, 0, 0, 0});
    vt.push_back('{"mtlo 6",       3'd5, 32'd6, 32'd9, 32'd5, 32'd6, 0, 0, 0});
    vt.push_back('{"div by 0",     3'd2, 32'd1234, 32'd0, 32'd5, 32'd6, 10, 0, 0});
    vt.push_back('{"divu by 0",    3'd3, 32'd9, 32'd0, 32'd5, 32'd6, 10, 0, 0});
    vt.push_back('{"div cancel4",  3'd2, 32'd100, 32'd3, 32'd5, 32'd6, 4, 4, 1});
    vt.push_back('{"divu cancel10",3'd3, 32'd100, 32'd3, 32'd5, 32'd6, 10, 10, 1});
    vt.push_back('{"op6 reserved", 3'd6, 32'hABCD, 32'd1, 32'd5, 32'd6, 0, 0, 0});
    vt.push_back('{"op7 reserved", 3'd7, 32'hABCD, 32'd1, 32'd5, 32'd6, 0, 0, 0});
    vt.push_back('{"div 7/-2",     3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10, 0, 0});

    // Reset held with an MTHI request and cancel toggling: outputs stay at zero.
    reset_n = 1'b0; sel = 1'b0; start = 1'b1; op_r = 3'd4; a_r = 32'hFFFF; b_r = '0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    check("reset busy", {31'h0, busy32}, 32'h0);
    check("reset hi", hi32, 32'h0);
    check("reset lo", lo32, 32'h0);
    check("reset hi16", {16'h0, hi16}, 32'h0);
    reset_n = 1'b1; start = 1'b0; cancel = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);

    foreach (vt[i])
      run_vec(vt[i].name, vt[i].op, vt[i].a, vt[i].b, vt[i].eh, vt[i].el,
              vt[i].en, vt[i].inj_at, vt[i].inj_cancel);

    // Cancel together with start in IDLE drops the request.
    start = 1'b1; op_r = 3'd4; a_r = 32'hDEAD_BEEF; cancel = 1'b1;
    @(negedge clk);
    check("cancel mthi hi", hi_s, m_hi);
    op_r = 3'd2; a_r = 32'd50; b_r = 32'd7;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel div busy", {31'h0, busy_s}, 32'h0);
    @(negedge clk);
    check("cancel div busy2", {31'h0, busy_s}, 32'h0);
    check("cancel div lo", lo_s, m_lo);

    // Asynchronous reset in the middle of a MULT.
    start = 1'b1; op_r = 3'd0; a_r = 32'd3; b_r = 32'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid-mult busy", {31'h0, busy_s}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async rst busy", {31'h0, busy_s}, 32'h0);
    check("async rst hi", hi_s, 32'h0);
    check("async rst lo", lo_s, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = '0; m_lo = '0;
    run_vec("post-rst mult", 3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd0, 32'd9, 5, 0, 0);

    for (int i = 0; i < 150; i++) rand_op(i);

    // Narrow configuration: 16-bit, single-cycle multiply, 33-cycle divide.
    sel = 1'b1; w = 16; nm = 1; nd = 33; m_hi = '0; m_lo = '0;
    @(negedge clk);
    run_vec("w16 mult -3x7", 3'd0, 32'hFFFD, 32'd7, 32'hFFFF, 32'hFFEB, 1, 0, 0);
    run_vec("w16 div min/-1", 3'd2, 32'h8000, 32'hFFFF, 32'h0, 32'h8000, 33, 0, 0);
    run_vec("w16 div -7/2", 3'd2, 32'hFFF9, 32'd2, 32'hFFFF, 32'hFFFD, 33, 0, 0);
    run_vec("w16 divu by 0", 3'd3, 32'd7, 32'd0, 32'hFFFF, 32'hFFFD, 33, 0, 0);
    run_vec("w16 mult cancel1", 3'd1, 32'd7, 32'd7, 32'hFFFF, 32'hFFFD, 1, 1, 1);
    for (int i = 0; i < 80; i++) rand_op(1000 + i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
